// File: rtl/a5_pkg.sv
// Shared constants, state encoding and helpers for the A5/1-style keystream generator.
package a5_pkg;

    localparam int R1_W = 19;
    localparam int R2_W = 22;
    localparam int R3_W = 23;

    localparam logic [R1_W-1:0] R1_TAPS = 19'h72000;
    localparam logic [R2_W-1:0] R2_TAPS = 22'h300000;
    localparam logic [R3_W-1:0] R3_TAPS = 23'h700080;

    localparam int R1_CLK = 8;
    localparam int R2_CLK = 10;
    localparam int R3_CLK = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_FRAME,
        ST_MIX,
        ST_OUT
    } a5_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/a5_lfsr_sync.sv
// One Galois-free Fibonacci shift register with synchronous clear and step enable.
module a5_lfsr_sync #(
    parameter int               WIDTH   = 19,
    parameter logic [WIDTH-1:0] TAPS    = '0,
    parameter int               CLK_BIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic msb,
    output logic clk_bit
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            sr <= '0;
        end else if (en) begin
            sr <= {sr[WIDTH-2:0], d ^ (^(sr & TAPS))};
        end
    end

    // msb is the value the register will hold after this edge, so the
    // output stage can register the keystream bit of the next state.
    assign msb     = en ? sr[WIDTH-2] : sr[WIDTH-1];
    assign clk_bit = sr[CLK_BIT];

endmodule

// File: rtl/a5_keystream_gen.sv
// Sequenced A5/1-style keystream core: serial key/frame load, mixing, then
// valid/ready keystream output.
module a5_keystream_gen
    import a5_pkg::*;
#(
    parameter int KEY_BITS   = 64,
    parameter int FRAME_BITS = 22,
    parameter int MIX_CYCLES = 100,
    parameter int OUT_BITS   = 228
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [KEY_BITS-1:0]   key,
    input  logic [FRAME_BITS-1:0] frame,
    output logic                  busy,
    output logic                  ks_valid,
    input  logic                  ks_ready,
    output logic                  ks_bit,
    output logic                  ks_last
);

    localparam int MAX_KF  = (KEY_BITS > FRAME_BITS) ? KEY_BITS : FRAME_BITS;
    localparam int MAX_MO  = (MIX_CYCLES > OUT_BITS) ? MIX_CYCLES : OUT_BITS;
    localparam int MAX_LEN = (MAX_KF > MAX_MO) ? MAX_KF : MAX_MO;
    localparam int CNT_W   = $clog2(MAX_LEN) + 1;

    localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_BITS - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] MIX_LAST   = CNT_W'(MIX_CYCLES - 1);
    localparam logic [CNT_W-1:0] OUT_LAST   = CNT_W'(OUT_BITS - 1);
    localparam logic [CNT_W-1:0] OUT_N      = CNT_W'(OUT_BITS);

    a5_state_t             state;
    logic [CNT_W-1:0]      cnt;
    logic [KEY_BITS-1:0]   key_sh;
    logic [FRAME_BITS-1:0] frame_sh;

    logic       clr;
    logic       d;
    logic       m;
    logic       fire;
    logic [2:0] en;
    logic [2:0] cbit;
    logic [2:0] nxt_msb;

    always_comb begin
        m    = maj3(cbit[0], cbit[1], cbit[2]);
        fire = (state == ST_OUT) && (!ks_valid || ks_ready) && (cnt < OUT_N);
        clr  = (state == ST_IDLE) && start;
        d    = 1'b0;
        en   = '0;
        case (state)
            ST_KEY: begin
                d  = key_sh[0];
                en = '1;
            end
            ST_FRAME: begin
                d  = frame_sh[0];
                en = '1;
            end
            ST_MIX:  en = ~(cbit ^ {3{m}});
            ST_OUT:  en = fire ? ~(cbit ^ {3{m}}) : 3'b000;
            default: en = '0;
        endcase
    end

    a5_lfsr_sync #(.WIDTH(R1_W), .TAPS(R1_TAPS), .CLK_BIT(R1_CLK)) u_r1 (
        .clk(clk), .reset(reset), .clr(clr), .en(en[0]), .d(d),
        .msb(nxt_msb[0]), .clk_bit(cbit[0])
    );

    a5_lfsr_sync #(.WIDTH(R2_W), .TAPS(R2_TAPS), .CLK_BIT(R2_CLK)) u_r2 (
        .clk(clk), .reset(reset), .clr(clr), .en(en[1]), .d(d),
        .msb(nxt_msb[1]), .clk_bit(cbit[1])
    );

    a5_lfsr_sync #(.WIDTH(R3_W), .TAPS(R3_TAPS), .CLK_BIT(R3_CLK)) u_r3 (
        .clk(clk), .reset(reset), .clr(clr), .en(en[2]), .d(d),
        .msb(nxt_msb[2]), .clk_bit(cbit[2])
    );

    // Key and frame shadows shift right so bit i is always at position 0 on load cycle i.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            key_sh   <= '0;
            frame_sh <= '0;
            busy     <= 1'b0;
            ks_valid <= 1'b0;
            ks_bit   <= 1'b0;
            ks_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        key_sh   <= key;
                        frame_sh <= frame;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= ST_KEY;
                    end
                end
                ST_KEY: begin
                    key_sh <= key_sh >> 1;
                    if (cnt == KEY_LAST) begin
                        cnt   <= '0;
                        state <= ST_FRAME;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_FRAME: begin
                    frame_sh <= frame_sh >> 1;
                    if (cnt == FRAME_LAST) begin
                        cnt   <= '0;
                        state <= ST_MIX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_MIX: begin
                    if (cnt == MIX_LAST) begin
                        cnt   <= '0;
                        state <= ST_OUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (fire) begin
                        ks_bit   <= ^nxt_msb;
                        ks_valid <= 1'b1;
                        ks_last  <= (cnt == OUT_LAST);
                        cnt      <= cnt + 1'b1;
                    end else if (ks_valid && ks_ready && ks_last) begin
                        ks_valid <= 1'b0;
                        ks_last  <= 1'b0;
                        ks_bit   <= 1'b0;
                        busy     <= 1'b0;
                        cnt      <= '0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a5_keystream_gen.sv
// Bench for a5_keystream_gen: software A5/1 model plus published test vector,
// at default and reduced parameters.
module tb_a5_keystream_gen;

    localparam logic [63:0]  TV_KEY   = 64'hEFCDAB8967452312;
    localparam logic [21:0]  TV_FRAME = 22'h134;
    localparam logic [119:0] TV_BITS  = 120'h534EAA582FE8151AB6E1855A728C00;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        d_start = 1'b0, d_ready = 1'b1;
    logic [63:0] d_key = '0;
    logic [21:0] d_frame = '0;
    logic        d_busy, d_valid, d_bit, d_last;

    logic        s_start = 1'b0, s_ready = 1'b1;
    logic [7:0]  s_key = '0;
    logic [3:0]  s_frame = '0;
    logic        s_busy, s_valid, s_bit, s_last;

    a5_keystream_gen dut (
        .clk(clk), .reset(reset), .start(d_start), .key(d_key), .frame(d_frame),
        .busy(d_busy), .ks_valid(d_valid), .ks_ready(d_ready), .ks_bit(d_bit), .ks_last(d_last)
    );

    a5_keystream_gen #(.KEY_BITS(8), .FRAME_BITS(4), .MIX_CYCLES(3), .OUT_BITS(5)) dut_small (
        .clk(clk), .reset(reset), .start(s_start), .key(s_key), .frame(s_frame),
        .busy(s_busy), .ks_valid(s_valid), .ks_ready(s_ready), .ks_bit(s_bit), .ks_last(s_last)
    );

    bit   sel = 1'b0;
    logic c_busy, c_valid, c_bit, c_last, c_ready;
    assign c_busy  = sel ? s_busy  : d_busy;
    assign c_valid = sel ? s_valid : d_valid;
    assign c_bit   = sel ? s_bit   : d_bit;
    assign c_last  = sel ? s_last  : d_last;
    assign c_ready = sel ? s_ready : d_ready;

    int tests = 0;
    int fails = 0;

    bit exp_bits[228];
    bit cap[228];
    int exp_n = 0;
    int idx = 0;
    int first_valid = -1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plain software A5/1: registers as integers, parity via popcount.
    task automatic compute_model(input logic [63:0] k, input logic [21:0] f,
                                 input int kb, input int fb, input int mc, input int ob);
        int unsigned r[3];
        int unsigned tap[3];
        int w[3];
        int cb[3];
        r   = '{0, 0, 0};
        tap = '{32'h72000, 32'h300000, 32'h700080};
        w   = '{19, 22, 23};
        cb  = '{8, 10, 10};
        exp_n = ob;
        for (int t = 0; t < kb + fb + mc + ob; t++) begin
            bit all_step;
            bit din;
            int ones;
            all_step = (t < kb + fb);
            din = (t < kb) ? k[t] : ((t < kb + fb) ? f[t - kb] : 1'b0);
            ones = int'((r[0] >> cb[0]) & 1) + int'((r[1] >> cb[1]) & 1) + int'((r[2] >> cb[2]) & 1);
            for (int i = 0; i < 3; i++) begin
                if (all_step || (((r[i] >> cb[i]) & 1) == ((ones >= 2) ? 1 : 0))) begin
                    r[i] = ((r[i] << 1) | (din ^ ($countones(r[i] & tap[i]) & 1)))
                           & ((32'd1 << w[i]) - 1);
                end
            end
            if (t >= kb + fb + mc)
                exp_bits[t - (kb + fb + mc)] = bit'(((r[0] >> 18) ^ (r[1] >> 21) ^ (r[2] >> 22)) & 1);
        end
    endtask

    function automatic logic [119:0] pack_bits(input bit from_cap);
        logic [119:0] v;
        v = '0;
        for (int i = 0; i < 114; i++) v[119 - i] = from_cap ? cap[i] : exp_bits[i];
        return v;
    endfunction

    function automatic int cap_ones();
        int n;
        n = 0;
        for (int i = 0; i < 228; i++) n += int'(cap[i]);
        return n;
    endfunction

    // Every cycle a bit is offered it must be the next model bit; a stall
    // re-checks the same index, so holds, drops and duplicates all show up.
    always @(negedge clk) begin
        if (!reset && c_valid) begin
            if (first_valid < 0) first_valid = cyc;
            if (idx < exp_n) begin
                check("ks_bit", c_bit, exp_bits[idx]);
                check("ks_last", c_last, (idx == exp_n - 1));
            end else begin
                check("bit_overrun", idx, exp_n - 1);
            end
            if (c_ready) begin
                if (idx < 228) cap[idx] = c_bit;
                idx++;
            end
        end
    end

    task automatic drive(input logic st, input logic [63:0] k, input logic [21:0] f, input logic rdy);
        if (sel) begin
            s_start = st; s_key = k[7:0]; s_frame = f[3:0]; s_ready = rdy;
            d_start = 1'b0; d_ready = 1'b1;
        end else begin
            d_start = st; d_key = k; d_frame = f; d_ready = rdy;
            s_start = 1'b0; s_ready = 1'b1;
        end
    endtask

    // ev: 0 plain, 1 key/frame change + start pulse mid-MIX,
    //     2 reset at S+100, 3 reset at S+250.
    task automatic run_session(input logic [63:0] k, input logic [21:0] f, input bit rnd,
                               input int ev, output int s_edge, output int fall);
        bit done;
        bit rst;
        logic st, rdy;
        idx = 0;
        first_valid = -1;
        fall = -1;
        done = 1'b0;
        drive(1'b1, k, f, 1'b1);
        tick();
        s_edge = cyc;
        check("busy_rise", c_busy, 1'b1);
        for (int n = 0; n < 3000 && !done; n++) begin
            rdy = rnd ? logic'($urandom_range(0, 2) != 0) : 1'b1;
            st  = (ev == 1) && (cyc == s_edge + 119);
            rst = ((ev == 2) && (cyc == s_edge + 99)) || ((ev == 3) && (cyc == s_edge + 249));
            drive(st, (ev == 1) ? ~k : k, (ev == 1) ? ~f : f, rdy);
            reset = rst;
            tick();
            if (rst) begin
                check("reset_outputs", {c_busy, c_valid, c_bit, c_last}, 4'b0000);
                reset = 1'b0;
                done = 1'b1;
            end else if (!c_busy) begin
                fall = cyc;
                done = 1'b1;
            end
        end
        check("session_done", done, 1'b1);
        drive(1'b0, k, f, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, fall, s2, fall2;

        drive(1'b0, '0, '0, 1'b1);
        reset = 1'b1;
        repeat (3) tick();
        check("reset_dut", {d_busy, d_valid, d_bit, d_last}, 4'b0000);
        check("reset_small", {s_busy, s_valid, s_bit, s_last}, 4'b0000);

        // Reset and start together: start is lost.
        drive(1'b1, TV_KEY, TV_FRAME, 1'b1);
        tick();
        reset = 1'b0;
        drive(1'b0, TV_KEY, TV_FRAME, 1'b1);
        tick();
        check("rst_start_busy", d_busy, 1'b0);
        tick();
        check("rst_start_valid", d_valid, 1'b0);

        // Test vector, ready always high.
        sel = 1'b0;
        compute_model(TV_KEY, TV_FRAME, 64, 22, 100, 228);
        check("model_vector", pack_bits(1'b0), TV_BITS);
        run_session(TV_KEY, TV_FRAME, 1'b0, 0, s, fall);
        check("tv_nbits", idx, 228);
        check("tv_vector", pack_bits(1'b1), TV_BITS);
        check("tv_first_valid", first_valid - s, 187);
        check("tv_busy_fall", fall - s, 415);

        // Same vector under random backpressure.
        run_session(TV_KEY, TV_FRAME, 1'b1, 0, s, fall);
        check("bp_nbits", idx, 228);
        check("bp_vector", pack_bits(1'b1), TV_BITS);

        // Start while busy and input changes after the start cycle are ignored.
        run_session(TV_KEY, TV_FRAME, 1'b0, 1, s, fall);
        check("ign_nbits", idx, 228);
        check("ign_vector", pack_bits(1'b1), TV_BITS);

        // Reset mid-MIX, then a full session.
        run_session(TV_KEY, TV_FRAME, 1'b0, 2, s, fall);
        run_session(TV_KEY, TV_FRAME, 1'b0, 0, s, fall);
        check("rmix_nbits", idx, 228);
        check("rmix_vector", pack_bits(1'b1), TV_BITS);

        // Reset during OUT, then a full session.
        run_session(TV_KEY, TV_FRAME, 1'b1, 3, s, fall);
        run_session(TV_KEY, TV_FRAME, 1'b0, 0, s, fall);
        check("rout_nbits", idx, 228);
        check("rout_vector", pack_bits(1'b1), TV_BITS);

        // All-zero key and frame keep every register at zero.
        compute_model('0, '0, 64, 22, 100, 228);
        check("model_zero", pack_bits(1'b0), 120'h0);
        run_session('0, '0, 1'b0, 0, s, fall);
        check("zero_nbits", idx, 228);
        check("zero_ones", cap_ones(), 0);
        check("zero_first_valid", first_valid - s, 187);
        check("zero_busy_fall", fall - s, 415);

        // Reduced parameters, then an immediate restart under backpressure.
        sel = 1'b1;
        compute_model(64'hA5, 22'h9, 8, 4, 3, 5);
        run_session(64'hA5, 22'h9, 1'b0, 0, s, fall);
        check("small_nbits", idx, 5);
        check("small_first_valid", first_valid - s, 16);
        check("small_busy_fall", fall - s, 21);
        run_session(64'hA5, 22'h9, 1'b1, 0, s2, fall2);
        check("small_restart_edge", s2, fall + 1);
        check("small_restart_nbits", idx, 5);

        compute_model(64'h3C, 22'h6, 8, 4, 3, 5);
        run_session(64'h3C, 22'h6, 1'b0, 0, s, fall);
        check("small2_nbits", idx, 5);

        sel = 1'b0;
        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/a5_keystream_gen.md
# a5_keystream_gen

Complete A5/1-style keystream generator built from three irregularly clocked LFSRs. It loads a session key and frame number serially, runs the mixing phase, then streams keystream bits through a valid/ready handshake. It sits between the wishbone register block, which supplies key, frame and start, and the cipher XOR datapath, which consumes bits. It replaces per-register instantiation with one sequenced core whose key, frame, mix and output lengths are parameters.

## Interface
- KEY_BITS, 64, number of key bits loaded
- FRAME_BITS, 22, number of frame-number bits loaded
- MIX_CYCLES, 100, majority-clocked cycles with output discarded
- OUT_BITS, 228, keystream bits produced per start
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a session; sampled only in IDLE
- key  in  KEY_BITS  session key; bit i is loaded at load cycle i
- frame  in  FRAME_BITS  frame number; bit i is loaded at frame cycle i
- busy  out  1  high in every state except IDLE
- ks_valid  out  1  ks_bit holds a valid keystream bit
- ks_ready  in  1  consumer accepts ks_bit when ks_valid & ks_ready
- ks_bit  out  1  keystream bit
- ks_last  out  1  qualifies the final (OUT_BITS-th) bit

## Operation
- Registers: R1 is 19 bits, taps 18,17,16,13, clock bit 8. R2 is 22 bits, taps 21,20, clock bit 10. R3 is 23 bits, taps 22,21,20,7, clock bit 10.
- A register step is: sr <= {sr[w-2:0], d ^ (XOR of tapped bits)}.
- Majority m = maj(R1[8], R2[10], R3[10]). A register steps with d=0 only if its clock bit equals m.
- FSM states: IDLE, KEY, FRAME, MIX, OUT.
- IDLE: outputs idle. start=1 latches key and frame into internal shadow registers, clears R1–R3 to 0, zeroes the counter, and moves to KEY.
- KEY: all three registers step unconditionally with d=key[cnt]. After KEY_BITS cycles, go to FRAME.
- FRAME: same as KEY with d=frame[cnt]. After FRAME_BITS cycles, go to MIX.
- MIX: majority clocking for MIX_CYCLES cycles, no output. Then go to OUT.
- OUT: whenever !ks_valid | ks_ready and bits produced < OUT_BITS:
  - majority-clock the registers;
  - register ks_bit = XOR of the MSBs of the *next* state;
  - set ks_valid=1; set ks_last=1 on the OUT_BITS-th bit.
  - When the last bit is accepted, clear ks_valid and return to IDLE.
- Backpressure: while ks_valid & !ks_ready, registers, counter, ks_bit and ks_last hold.
- start while busy is ignored. key and frame changes after the start cycle have no effect.
- Counter: a single counter of clog2(max of the four parameters)+1 bits, cleared on every state change. It does not wrap.
- Reset: any cycle, any state. Next edge gives IDLE, R1–R3=0, busy=0, ks_valid=0, ks_bit=0, ks_last=0. Any session in progress is discarded.

## Timing
- Reset values of all outputs: busy=0, ks_valid=0, ks_bit=0, ks_last=0.
- busy rises on the edge after start is sampled (cycle S+1).
- KEY occupies cycles S+1..S+64 and FRAME S+65..S+86 at default parameters.
- MIX occupies the next 100 cycles.
- First ks_valid appears at cycle S+1+KEY_BITS+FRAME_BITS+MIX_CYCLES (S+187 at default parameters).
- With ks_ready held high, one bit per cycle. The last bit is at S+414 and busy falls on the following edge.
- Earliest restart: start is accepted on the first cycle back in IDLE.
- Simultaneous reset and start: reset wins and start is lost.

## Structure
- Package a5_pkg holds:
  - register widths, tap masks (19'h72000, 22'h300000, 23'h700080) and clock-bit indices;
  - the state enum;
  - a majority function.
- Sub-module a5_lfsr_sync holds one register, with parameters WIDTH, TAPS and CLK_BIT.
  - Ports: clk, reset, clr, en, d, msb, clk_bit.
  - Instantiated three times.
- FSM, counter, output register and key/frame shadow registers live in the top module.

## Test plan
- Key 64'hEFCDAB8967452312, frame 22'h134, ks_ready=1 → the first 114 bits, packed MSB-first per byte, equal 534EAA582FE8151AB6E1855A728C00. ks_last is asserted only on bit 228.
- Same run with ks_ready toggled pseudo-randomly → identical bit sequence. No bit is lost or duplicated while ks_valid & !ks_ready; ks_bit stays stable while stalled.
- start pulsed again mid-MIX, and key changed after the start cycle → output identical to the first scenario.
- Reset asserted at cycle S+100 (mid-MIX) and again during OUT → all outputs 0 on the next edge. A new start then reproduces the first-scenario vector exactly.
- Key=0, frame=0 → registers stay 0 through KEY and FRAME, and all 228 ks_bit values are 0. Timing per the Timing section, including busy fall at S+415.
- Reduced parameters KEY_BITS=8, FRAME_BITS=4, MIX_CYCLES=3, OUT_BITS=5 → the sequence matches a software reference model. ks_valid first appears at S+16 and exactly 5 bits are produced.
